// File: rtl/drp_responder_pkg.sv
// Shared widths, FSM encoding and latency helper for the DRP responder.
package drp_responder_pkg;

    localparam int DRP_AW = 5;
    localparam int DRP_DW = 16;
    localparam int LAT_W  = 4;
    localparam int LOCK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drp_state_e;

    // Counter preload so that DRDY lands exactly LAT cycles after the accepted DEN.
    function automatic logic [LAT_W-1:0] lat_load(input logic we,
                                                  input int unsigned rd_lat,
                                                  input int unsigned wr_lat);
        logic [LAT_W-1:0] val;
        if (we) begin
            val = LAT_W'(wr_lat - 32'd1);
        end else begin
            val = LAT_W'(rd_lat - 32'd1);
        end
        return val;
    endfunction

endpackage

// File: rtl/drp_lock_model.sv
// PLL lock model: LOCKED rises once RST_PLL has been low for LOCK_CYC edges.
module drp_lock_model
    import drp_responder_pkg::*;
#(
    parameter int unsigned LOCK_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rst_pll_i,
    output logic locked_o
);

    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CYC);

    logic [LOCK_W-1:0] cnt_q;
    logic [LOCK_W-1:0] cnt_d;
    logic              locked_q;

    // Next count: cleared by RST_PLL, otherwise counts up and saturates at the target.
    always_comb begin
        cnt_d = cnt_q;
        if (rst_pll_i) begin
            cnt_d = {LOCK_W{1'b0}};
        end else if (cnt_q < LOCK_TGT) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count and registered lock flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= {LOCK_W{1'b0}};
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= (cnt_d == LOCK_TGT);
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/drp_responder.sv
// DRP slave standing in for PLL_ADV: 32x16 register bank, programmable
// access latency, protocol-error flag and a PLL lock model.
module drp_responder
    import drp_responder_pkg::*;
#(
    parameter int unsigned RD_LAT   = 4,
    parameter int unsigned WR_LAT   = 4,
    parameter int unsigned LOCK_CYC = 64
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              DEN,
    input  logic              DWE,
    input  logic [DRP_AW-1:0] DADDR,
    input  logic [DRP_DW-1:0] DI,
    output logic [DRP_DW-1:0] DO,
    output logic              DRDY,
    input  logic              RST_PLL,
    output logic              LOCKED,
    output logic              BUSY,
    output logic              PROTO_ERR
);

    localparam int NREG = 32;

    drp_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d, lat_ld;
    logic              we_q, we_d;
    logic [DRP_AW-1:0] addr_q, addr_d;
    logic [DRP_DW-1:0] wdata_q, wdata_d;
    logic [DRP_DW-1:0] mem_q [NREG];
    logic              drdy_q, drdy_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;
    logic [DRP_DW-1:0] do_q, do_d;

    assign lat_ld = lat_load(DWE, RD_LAT, WR_LAT);

    // Transaction FSM; outputs are precomputed from the next state so they come straight off flops.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (DEN) begin
                    we_d    = DWE;
                    addr_d  = DADDR;
                    wdata_d = DI;
                    lat_d   = lat_ld;
                    if (lat_ld == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (DEN) begin
                    perr_d = 1'b1;
                end else begin
                    perr_d = perr_q;
                end
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (DEN) begin
                    perr_d = 1'b1;
                end else begin
                    perr_d = perr_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drdy_d = (state_d == RESP);
        busy_d = (state_d == WAIT);
        // No write can retire on the edge a read enters RESP, so the bank is current here.
        if ((state_d == RESP) && !we_d) begin
            do_d = mem_q[addr_d];
        end else begin
            do_d = {DRP_DW{1'b0}};
        end
    end

    // FSM state, captured request and registered outputs.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= IDLE;
            lat_q   <= {LAT_W{1'b0}};
            we_q    <= 1'b0;
            addr_q  <= {DRP_AW{1'b0}};
            wdata_q <= {DRP_DW{1'b0}};
            drdy_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            do_q    <= {DRP_DW{1'b0}};
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drdy_q  <= drdy_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
            do_q    <= do_d;
        end
    end

    // Register bank; a write retires at the end of its RESP cycle.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DRP_DW{1'b0}};
            end
        end else if ((state_q == RESP) && we_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    drp_lock_model #(
        .LOCK_CYC(LOCK_CYC)
    ) u_lock (
        .clk_i    (CLK),
        .rst_n_i  (RSTX),
        .rst_pll_i(RST_PLL),
        .locked_o (LOCKED)
    );

    assign DO        = do_q;
    assign DRDY      = drdy_q;
    assign BUSY      = busy_q;
    assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: a default-latency instance and a latency-1 instance
// driven with the same stimulus, each checked against a transaction-level model.
module tb_drp_responder;

    logic        clk = 1'b0;
    logic        rstx, den, dwe, rst_pll;
    logic [4:0]  daddr;
    logic [15:0] di;
    logic [15:0] do_w     [2];
    logic        drdy_w   [2];
    logic        locked_w [2];
    logic        busy_w   [2];
    logic        perr_w   [2];

    always #5 clk = ~clk;

    drp_responder #(.RD_LAT(4), .WR_LAT(4), .LOCK_CYC(64)) u_a (
        .CLK(clk), .RSTX(rstx), .DEN(den), .DWE(dwe), .DADDR(daddr), .DI(di),
        .DO(do_w[0]), .DRDY(drdy_w[0]), .RST_PLL(rst_pll), .LOCKED(locked_w[0]),
        .BUSY(busy_w[0]), .PROTO_ERR(perr_w[0]));

    drp_responder #(.RD_LAT(1), .WR_LAT(1), .LOCK_CYC(5)) u_b (
        .CLK(clk), .RSTX(rstx), .DEN(den), .DWE(dwe), .DADDR(daddr), .DI(di),
        .DO(do_w[1]), .DRDY(drdy_w[1]), .RST_PLL(rst_pll), .LOCKED(locked_w[1]),
        .BUSY(busy_w[1]), .PROTO_ERR(perr_w[1]));

    localparam int RDL [2] = '{4, 1};
    localparam int WRL [2] = '{4, 1};
    localparam int LKC [2] = '{64, 5};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: at most one outstanding request per instance, completing at cycle 'due'.
    bit          pend  [2];
    int          due   [2];
    bit          p_we  [2];
    logic [4:0]  p_addr[2];
    logic [15:0] p_di  [2];
    logic [15:0] mem   [2][32];
    bit          perr  [2];
    int          lk    [2];

    logic        act_drdy [2];
    logic [15:0] act_do   [2];
    logic        act_lock [2];
    logic        act_perr [2];

    typedef struct {
        logic        den;
        logic        dwe;
        logic [4:0]  addr;
        logic [15:0] di;
        logic        drdy;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl [15];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic vec_t mkv(input logic d, input logic w, input logic [4:0] a,
                                 input logic [15:0] x, input logic r, input logic [15:0] o);
        vec_t v;
        v.den = d; v.dwe = w; v.addr = a; v.di = x; v.drdy = r; v.dout = o;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0;
            perr[i] = 1'b0;
            lk[i]   = 0;
            for (int a = 0; a < 32; a++) mem[i][a] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        rstx = 1'b0; den = 1'b0; dwe = 1'b0; daddr = 5'h00; di = 16'h0000; rst_pll = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_drdy%0d", i), {31'd0, drdy_w[i]}, 32'd0);
            chk($sformatf("rst_do%0d", i), {16'd0, do_w[i]}, 32'd0);
            chk($sformatf("rst_locked%0d", i), {31'd0, locked_w[i]}, 32'd0);
            chk($sformatf("rst_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
            chk($sformatf("rst_perr%0d", i), {31'd0, perr_w[i]}, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rstx = 1'b1;
    endtask

    // One clock cycle: drive, check both instances mid-cycle, then advance the model.
    task automatic tick(input logic i_den, input logic i_dwe, input logic [4:0] i_addr,
                        input logic [15:0] i_di, input logic i_rp);
        den = i_den; dwe = i_dwe; daddr = i_addr; di = i_di; rst_pll = i_rp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit          ed;
            bit          was_pend;
            logic [15:0] edo;
            ed  = pend[i] && (cyc == due[i]);
            edo = (ed && !p_we[i]) ? mem[i][p_addr[i]] : 16'h0000;
            chk($sformatf("drdy%0d", i), {31'd0, drdy_w[i]}, {31'd0, ed});
            chk($sformatf("do%0d", i), {16'd0, do_w[i]}, {16'd0, edo});
            chk($sformatf("busy%0d", i), {31'd0, busy_w[i]}, {31'd0, pend[i] && (cyc < due[i])});
            chk($sformatf("perr%0d", i), {31'd0, perr_w[i]}, {31'd0, perr[i]});
            chk($sformatf("locked%0d", i), {31'd0, locked_w[i]}, {31'd0, lk[i] >= LKC[i]});
            act_drdy[i] = drdy_w[i];
            act_do[i]   = do_w[i];
            act_lock[i] = locked_w[i];
            act_perr[i] = perr_w[i];

            was_pend = pend[i];
            if (was_pend && (cyc == due[i])) begin
                if (p_we[i]) mem[i][p_addr[i]] = p_di[i];
                pend[i] = 1'b0;
            end
            if (i_den) begin
                if (was_pend) begin
                    perr[i] = 1'b1;
                end else begin
                    pend[i]   = 1'b1;
                    p_we[i]   = i_dwe;
                    p_addr[i] = i_addr;
                    p_di[i]   = i_di;
                    due[i]    = cyc + (i_dwe ? WRL[i] : RDL[i]);
                end
            end
            if (i_rp) lk[i] = 0;
            else if (lk[i] < LKC[i]) lk[i] = lk[i] + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [15:0] wd [8];

        tbl[0]  = mkv(1'b1, 1'b1, 5'h08, 16'hA5C3, 1'b0, 16'h0000);
        tbl[1]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[2]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[3]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[4]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 16'h0000);
        tbl[5]  = mkv(1'b1, 1'b0, 5'h08, 16'h0000, 1'b0, 16'h0000);
        tbl[6]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[7]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[8]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[9]  = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 16'hA5C3);
        tbl[10] = mkv(1'b1, 1'b0, 5'h1F, 16'h0000, 1'b0, 16'h0000);
        tbl[11] = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[12] = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[13] = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 16'h0000);
        tbl[14] = mkv(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 16'h0000);

        // Lock rise after reset release.
        do_reset();
        for (int k = 0; k < 70; k++) begin
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
            if (k == 63) chk("lock_before", {31'd0, act_lock[0]}, 32'd0);
            if (k == 64) chk("lock_after", {31'd0, act_lock[0]}, 32'd1);
        end

        // Write/read and unwritten-address vectors.
        for (int k = 0; k < 15; k++) begin
            tick(tbl[k].den, tbl[k].dwe, tbl[k].addr, tbl[k].di, 1'b0);
            chk($sformatf("tbl%0d_drdy", k), {31'd0, act_drdy[0]}, {31'd0, tbl[k].drdy});
            chk($sformatf("tbl%0d_do", k), {16'd0, act_do[0]}, {16'd0, tbl[k].dout});
        end

        // RST_PLL pulse of three cycles while locked.
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b1);
            if (k == 0) chk("rp_lock_still", {31'd0, act_lock[0]}, 32'd1);
            if (k == 1) chk("rp_lock_drop", {31'd0, act_lock[0]}, 32'd0);
        end
        for (int k = 0; k < 66; k++) begin
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
            if (k == 63) chk("relock_before", {31'd0, act_lock[0]}, 32'd0);
            if (k == 64) chk("relock_after", {31'd0, act_lock[0]}, 32'd1);
        end

        // Second DEN while busy is dropped and flagged.
        do_reset();
        cnt = 0;
        tick(1'b1, 1'b0, 5'h02, 16'h0000, 1'b0);
        cnt += int'(act_drdy[0]);
        tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
        cnt += int'(act_drdy[0]);
        tick(1'b1, 1'b1, 5'h02, 16'hFFFF, 1'b0);
        cnt += int'(act_drdy[0]);
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
            cnt += int'(act_drdy[0]);
        end
        chk("perr_drdy_count", cnt, 32'd1);
        chk("perr_set", {31'd0, act_perr[0]}, 32'd1);
        tick(1'b1, 1'b0, 5'h02, 16'h0000, 1'b0);
        idle(3);
        tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
        chk("perr_rd_drdy", {31'd0, act_drdy[0]}, 32'd1);
        chk("perr_rd_do", {16'd0, act_do[0]}, 32'h0000);
        chk("perr_sticky", {31'd0, act_perr[0]}, 32'd1);

        // Reset in the middle of a write abandons it.
        tick(1'b1, 1'b1, 5'h03, 16'h1234, 1'b0);
        idle(2);
        do_reset();
        idle(6);
        tick(1'b1, 1'b0, 5'h03, 16'h0000, 1'b0);
        idle(5);

        // Latency-1 instance: back-to-back requests every two cycles.
        do_reset();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            wd[k] = 16'($urandom);
            tick(1'b1, 1'b1, 5'(k), wd[k], 1'b0);
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
            cnt += int'(act_drdy[1]);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b0, 5'(k), 16'h0000, 1'b0);
            tick(1'b0, 1'b0, 5'h00, 16'h0000, 1'b0);
            cnt += int'(act_drdy[1]);
            chk($sformatf("b2b_rd%0d", k), {16'd0, act_do[1]}, {16'd0, wd[k]});
        end
        chk("b2b_drdy_count", cnt, 32'd16);
        chk("b2b_no_perr", {31'd0, act_perr[1]}, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            tick(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, 1'($urandom), 5'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
